// File: rtl/fetch_stage_pkg.sv
// Shared constants, state encoding and address helper for the IF stage
// and its pipeline register.
package fetch_stage_pkg;

   localparam logic [31:0] PC_RESET_DEFAULT  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      HOLD    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_t;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & ~32'd3;
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the IF stage (master)
// and the instruction memory (slave).
interface fetch_stage_if;
   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] rdata;

   modport master (output req, addr, input ack, rdata);
   modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register with flush > hold > load priority; an idle cycle
// (no hold, no load) inserts a bubble.
module ifid_reg
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        flush,
   input  logic        hold,
   input  logic        load,
   input  logic [31:0] load_instr,
   input  logic [31:0] load_pc4,
   output logic [31:0] instr,
   output logic [31:0] pc4,
   output logic        valid
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         instr <= NOP_INSTR;
         pc4   <= '0;
         valid <= 1'b0;
      end else if (flush) begin
         instr <= NOP_INSTR;
         valid <= 1'b0;
      end else if (!hold) begin
         if (load) begin
            instr <= load_instr;
            pc4   <= load_pc4;
            valid <= 1'b1;
         end else begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, imem req/ack FSM with one-entry skid buffer and
// stale-fetch discard, feeding the IF/ID pipeline register.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] PC_RESET  = PC_RESET_DEFAULT,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 pc_write,
   input  logic                 ifid_write,
   input  logic                 bubble_ifid,
   input  logic                 PCSrc,
   input  logic [31:0]          branch_target,
   input  logic                 Jump,
   input  logic [31:0]          jump_target,
   fetch_stage_if.master        imem,
   output logic [31:0]          pc,
   output logic [31:0]          ifid_instr,
   output logic [31:0]          ifid_pc4,
   output logic                 ifid_valid
);

   fetch_state_t state;
   logic         req_q;
   logic [31:0]  redirect_pc;
   logic [31:0]  skid_instr;
   logic [31:0]  skid_pc4;

   logic         redirect;
   logic [31:0]  target;
   logic [31:0]  pc_plus4;
   logic         ack_ok;
   logic         ifid_load;
   logic [31:0]  ifid_load_instr;
   logic [31:0]  ifid_load_pc4;

   assign imem.req  = req_q;
   assign imem.addr = pc;

   // PCSrc belongs to the older instruction, so it wins over Jump.
   assign redirect = PCSrc | Jump;
   assign target   = word_align(PCSrc ? branch_target : jump_target);
   assign pc_plus4 = pc + 32'd4;
   assign ack_ok   = req_q & imem.ack;

   always_comb begin
      ifid_load       = 1'b0;
      ifid_load_instr = imem.rdata;
      ifid_load_pc4   = pc_plus4;
      case (state)
         FETCH:   ifid_load = ack_ok & ~redirect;
         HOLD: begin
            ifid_load       = ~redirect;
            ifid_load_instr = skid_instr;
            ifid_load_pc4   = skid_pc4;
         end
         default: ifid_load = 1'b0;
      endcase
   end

   // req only rises a cycle after reset release, so a stale ack from an
   // abandoned pre-reset request is ignored while req_q is still low.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= FETCH;
         pc          <= word_align(PC_RESET);
         req_q       <= 1'b0;
         redirect_pc <= '0;
         skid_instr  <= NOP_INSTR;
         skid_pc4    <= '0;
      end else begin
         case (state)
            FETCH: begin
               if (!req_q) begin
                  req_q <= 1'b1;
                  if (redirect) pc <= target;
               end else if (redirect) begin
                  if (imem.ack) begin
                     pc <= target;
                  end else begin
                     redirect_pc <= target;
                     state       <= DISCARD;
                  end
               end else if (imem.ack) begin
                  if (ifid_write) begin
                     skid_instr <= imem.rdata;
                     skid_pc4   <= pc_plus4;
                     state      <= HOLD;
                     req_q      <= 1'b0;
                  end else if (!pc_write) begin
                     pc <= pc_plus4;
                  end
               end
            end
            HOLD: begin
               if (redirect) begin
                  pc    <= target;
                  state <= FETCH;
                  req_q <= 1'b1;
               end else if (!ifid_write) begin
                  pc    <= skid_pc4;
                  state <= FETCH;
                  req_q <= 1'b1;
               end
            end
            DISCARD: begin
               if (redirect) redirect_pc <= target;
               if (imem.ack) begin
                  pc    <= redirect ? target : redirect_pc;
                  state <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

   ifid_reg #(
      .NOP_INSTR(NOP_INSTR)
   ) u_ifid (
      .clock      (clock),
      .reset      (reset),
      .flush      (bubble_ifid),
      .hold       (ifid_write),
      .load       (ifid_load),
      .load_instr (ifid_load_instr),
      .load_pc4   (ifid_load_pc4),
      .instr      (ifid_instr),
      .pc4        (ifid_pc4),
      .valid      (ifid_valid)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: two instances (PC_RESET 0 and 0x100) each on a
// variable-latency memory model, IF/ID results checked through a scoreboard.
module tb_fetch_stage;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
   } ifid_t;

   logic        clock;
   logic        reset;
   logic        pc_write, ifid_write, bubble_ifid;
   logic        PCSrc, Jump;
   logic [31:0] branch_target, jump_target;

   logic [31:0] pc0, ii0, ip0, pc1, ii1, ip1;
   logic        iv0, iv1;

   int          lat0, lat1, cnt0, cnt1;
   bit          en0, en1;
   int          n_vec = 0;
   int          n_err = 0;
   ifid_t       sb[$];

   fetch_stage_if bus0 ();
   fetch_stage_if bus1 ();

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {16'hAAAA, a[17:2]};
   endfunction

   function automatic ifid_t exp_entry(input logic [31:0] a);
      ifid_t e;
      e.instr = mem_word(a);
      e.pc4   = a + 32'd4;
      return e;
   endfunction

   // Memory model: ack after lat cycles of req, gated by en.
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt0 <= 0;
         cnt1 <= 0;
      end else begin
         cnt0 <= (bus0.req && !bus0.ack) ? cnt0 + 1 : 0;
         cnt1 <= (bus1.req && !bus1.ack) ? cnt1 + 1 : 0;
      end
   end

   assign bus0.ack   = bus0.req & en0 & (cnt0 >= lat0);
   assign bus1.ack   = bus1.req & en1 & (cnt1 >= lat1);
   assign bus0.rdata = mem_word(bus0.addr);
   assign bus1.rdata = mem_word(bus1.addr);

   fetch_stage #(.PC_RESET(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut0 (
      .clock(clock), .reset(reset), .pc_write(pc_write), .ifid_write(ifid_write),
      .bubble_ifid(bubble_ifid), .PCSrc(PCSrc), .branch_target(branch_target),
      .Jump(Jump), .jump_target(jump_target), .imem(bus0), .pc(pc0),
      .ifid_instr(ii0), .ifid_pc4(ip0), .ifid_valid(iv0));

   fetch_stage #(.PC_RESET(32'h0000_0100), .NOP_INSTR(32'h0000_0000)) dut1 (
      .clock(clock), .reset(reset), .pc_write(pc_write), .ifid_write(ifid_write),
      .bubble_ifid(bubble_ifid), .PCSrc(PCSrc), .branch_target(branch_target),
      .Jump(Jump), .jump_target(jump_target), .imem(bus1), .pc(pc1),
      .ifid_instr(ii1), .ifid_pc4(ip1), .ifid_valid(iv1));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no finish want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      pc_write = 1'b0; ifid_write = 1'b0; bubble_ifid = 1'b0;
      PCSrc = 1'b0; Jump = 1'b0; branch_target = '0; jump_target = '0;
      en0 = 1'b1; en1 = 1'b1; lat0 = 0; lat1 = 2;
      sb.delete();
      repeat (2) @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      pc_write = 1'b0; ifid_write = 1'b0; bubble_ifid = 1'b0;
      PCSrc = 1'b0; Jump = 1'b0; branch_target = '0; jump_target = '0;
      en0 = 1'b1; en1 = 1'b1; lat0 = 0; lat1 = 2;
      #1 reset = 1'b0;
      repeat (2) @(negedge clock);
      n_vec++; if (bus0.req !== 1'b0) begin n_err++; $display("FAIL rst_req0: got %b want 0", bus0.req); end
      n_vec++; if (bus0.addr !== 32'h0) begin n_err++; $display("FAIL rst_addr0: got %h want 00000000", bus0.addr); end
      n_vec++; if ({ii0, ip0, iv0} !== 65'd0) begin n_err++; $display("FAIL rst_ifid0: got %h/%h/%b want 0/0/0", ii0, ip0, iv0); end
      n_vec++; if (pc1 !== 32'h100) begin n_err++; $display("FAIL rst_pc1: got %h want 00000100", pc1); end
      n_vec++; if (bus1.req !== 1'b0) begin n_err++; $display("FAIL rst_req1: got %b want 0", bus1.req); end
   endtask

   task automatic test_zero_wait();
      ifid_t e;
      do_reset();
      for (int i = 0; i < 4; i++) sb.push_back(exp_entry(32'(4 * i)));
      @(negedge clock);
      n_vec++; if (bus0.req !== 1'b1 || bus0.addr !== 32'h0) begin n_err++; $display("FAIL zw_first_req: got %b@%h want 1@00000000", bus0.req, bus0.addr); end
      n_vec++; if (iv0 !== 1'b0) begin n_err++; $display("FAIL zw_first_valid: got %b want 0", iv0); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         n_vec++; if (bus0.addr !== 32'(4 * (i + 1))) begin n_err++; $display("FAIL zw_addr[%0d]: got %h want %h", i, bus0.addr, 32'(4 * (i + 1))); end
         n_vec++; if (iv0 !== 1'b1) begin n_err++; $display("FAIL zw_valid[%0d]: got %b want 1", i, iv0); end
         e = sb.pop_front();
         n_vec++; if ({ii0, ip0} !== {e.instr, e.pc4}) begin n_err++; $display("FAIL zw_ifid[%0d]: got %h/%h want %h/%h", i, ii0, ip0, e.instr, e.pc4); end
      end
   endtask

   task automatic test_wait_states();
      ifid_t e;
      do_reset();
      sb.push_back(exp_entry(32'h100));
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         n_vec++; if (bus1.addr !== 32'h100 || bus1.req !== 1'b1) begin n_err++; $display("FAIL ws_hold_addr[%0d]: got %b@%h want 1@00000100", i, bus1.req, bus1.addr); end
         n_vec++; if (iv1 !== 1'b0) begin n_err++; $display("FAIL ws_bubble[%0d]: got %b want 0", i, iv1); end
      end
      @(negedge clock);
      n_vec++; if (bus1.addr !== 32'h104) begin n_err++; $display("FAIL ws_next_addr: got %h want 00000104", bus1.addr); end
      e = sb.pop_front();
      n_vec++; if ({ii1, ip1, iv1} !== {e.instr, e.pc4, 1'b1}) begin n_err++; $display("FAIL ws_ifid: got %h/%h/%b want %h/%h/1", ii1, ip1, iv1, e.instr, e.pc4); end
   endtask

   task automatic test_skid();
      ifid_t e;
      do_reset();
      sb.push_back(exp_entry(32'h0));
      sb.push_back(exp_entry(32'h4));
      @(negedge clock);
      @(negedge clock);
      e = sb.pop_front();
      n_vec++; if ({ii0, ip0, iv0} !== {e.instr, e.pc4, 1'b1}) begin n_err++; $display("FAIL sk_first: got %h/%h/%b want %h/%h/1", ii0, ip0, iv0, e.instr, e.pc4); end
      ifid_write = 1'b1; pc_write = 1'b1;
      @(negedge clock);
      n_vec++; if (bus0.req !== 1'b0 || bus0.addr !== 32'h4) begin n_err++; $display("FAIL sk_hold1: got %b@%h want 0@00000004", bus0.req, bus0.addr); end
      @(negedge clock);
      n_vec++; if (bus0.req !== 1'b0) begin n_err++; $display("FAIL sk_hold2_req: got %b want 0", bus0.req); end
      n_vec++; if (ii0 !== mem_word(32'h0)) begin n_err++; $display("FAIL sk_held_ifid: got %h want %h", ii0, mem_word(32'h0)); end
      ifid_write = 1'b0; pc_write = 1'b0;
      @(negedge clock);
      e = sb.pop_front();
      n_vec++; if ({ii0, ip0, iv0} !== {e.instr, e.pc4, 1'b1}) begin n_err++; $display("FAIL sk_release: got %h/%h/%b want %h/%h/1", ii0, ip0, iv0, e.instr, e.pc4); end
      n_vec++; if (bus0.req !== 1'b1 || bus0.addr !== 32'h8) begin n_err++; $display("FAIL sk_resume: got %b@%h want 1@00000008", bus0.req, bus0.addr); end
      @(negedge clock);
      n_vec++; if (ip0 !== 32'hC) begin n_err++; $display("FAIL sk_next_pc4: got %h want 0000000c", ip0); end
   endtask

   task automatic test_discard();
      ifid_t e;
      int guard = 0;
      do_reset();
      do begin
         @(negedge clock);
         guard++;
      end while (bus0.addr !== 32'h20 && guard < 20);
      n_vec++; if (bus0.addr !== 32'h20) begin n_err++; $display("FAIL dc_reach_timeout: got %h want 00000020", bus0.addr); end
      en0 = 1'b0; PCSrc = 1'b1; branch_target = 32'h40;
      sb.push_back(exp_entry(32'h40));
      @(negedge clock);
      PCSrc = 1'b0;
      n_vec++; if (bus0.req !== 1'b1 || bus0.addr !== 32'h20) begin n_err++; $display("FAIL dc_pending: got %b@%h want 1@00000020", bus0.req, bus0.addr); end
      n_vec++; if (iv0 !== 1'b0) begin n_err++; $display("FAIL dc_bubble1: got %b want 0", iv0); end
      @(negedge clock);
      n_vec++; if (bus0.addr !== 32'h20 || iv0 !== 1'b0) begin n_err++; $display("FAIL dc_wait: got %h/%b want 00000020/0", bus0.addr, iv0); end
      en0 = 1'b1;
      @(negedge clock);
      n_vec++; if (bus0.addr !== 32'h40 || iv0 !== 1'b0) begin n_err++; $display("FAIL dc_dropped: got %h/%b want 00000040/0", bus0.addr, iv0); end
      @(negedge clock);
      e = sb.pop_front();
      n_vec++; if ({ii0, ip0, iv0} !== {e.instr, e.pc4, 1'b1}) begin n_err++; $display("FAIL dc_target_ifid: got %h/%h/%b want %h/%h/1", ii0, ip0, iv0, e.instr, e.pc4); end
   endtask

   task automatic test_redirect_priority();
      ifid_t e;
      do_reset();
      repeat (3) @(negedge clock);
      PCSrc = 1'b1; branch_target = 32'h80; Jump = 1'b1; jump_target = 32'h200; bubble_ifid = 1'b1;
      @(negedge clock);
      PCSrc = 1'b0; Jump = 1'b0; bubble_ifid = 1'b0;
      n_vec++; if (bus0.addr !== 32'h80) begin n_err++; $display("FAIL rp_addr: got %h want 00000080", bus0.addr); end
      n_vec++; if ({ii0, ip0, iv0} !== {32'h0, 32'h8, 1'b0}) begin n_err++; $display("FAIL rp_flush: got %h/%h/%b want 00000000/00000008/0", ii0, ip0, iv0); end
      sb.push_back(exp_entry(32'h80));
      @(negedge clock);
      e = sb.pop_front();
      n_vec++; if ({ii0, ip0, iv0} !== {e.instr, e.pc4, 1'b1}) begin n_err++; $display("FAIL rp_branch_ifid: got %h/%h/%b want %h/%h/1", ii0, ip0, iv0, e.instr, e.pc4); end
      Jump = 1'b1; jump_target = 32'h203;
      @(negedge clock);
      Jump = 1'b0;
      n_vec++; if (bus0.addr !== 32'h200 || iv0 !== 1'b0) begin n_err++; $display("FAIL rp_jump: got %h/%b want 00000200/0", bus0.addr, iv0); end
      sb.push_back(exp_entry(32'h200));
      @(negedge clock);
      e = sb.pop_front();
      n_vec++; if ({ii0, ip0, iv0} !== {e.instr, e.pc4, 1'b1}) begin n_err++; $display("FAIL rp_jump_ifid: got %h/%h/%b want %h/%h/1", ii0, ip0, iv0, e.instr, e.pc4); end
      PCSrc = 1'b1; branch_target = 32'hFFFF_FFFF;
      sb.push_back(exp_entry(32'hFFFF_FFFC));
      @(negedge clock);
      PCSrc = 1'b0;
      n_vec++; if (bus0.addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL rp_align: got %h want fffffffc", bus0.addr); end
      @(negedge clock);
      e = sb.pop_front();
      n_vec++; if ({ii0, ip0, iv0} !== {e.instr, e.pc4, 1'b1}) begin n_err++; $display("FAIL rp_wrap_ifid: got %h/%h/%b want %h/%h/1", ii0, ip0, iv0, e.instr, e.pc4); end
      n_vec++; if (bus0.addr !== 32'h0) begin n_err++; $display("FAIL rp_wrap_addr: got %h want 00000000", bus0.addr); end
   endtask

   task automatic test_reset_midwait();
      ifid_t e;
      do_reset();
      repeat (3) @(negedge clock);
      en0 = 1'b0; ifid_write = 1'b1;
      @(negedge clock);
      n_vec++; if (bus0.req !== 1'b1 || bus0.addr !== 32'h8 || iv0 !== 1'b1) begin n_err++; $display("FAIL rm_pending: got %b@%h/%b want 1@00000008/1", bus0.req, bus0.addr, iv0); end
      #2 reset = 1'b0;
      #1;
      n_vec++; if (bus0.req !== 1'b0 || bus0.addr !== 32'h0) begin n_err++; $display("FAIL rm_async_bus: got %b@%h want 0@00000000", bus0.req, bus0.addr); end
      n_vec++; if ({ii0, ip0, iv0} !== 65'd0) begin n_err++; $display("FAIL rm_async_ifid: got %h/%h/%b want 0/0/0", ii0, ip0, iv0); end
      sb.push_back(exp_entry(32'h0));
      @(negedge clock);
      reset = 1'b1; en0 = 1'b1; ifid_write = 1'b0;
      @(negedge clock);
      n_vec++; if (bus0.req !== 1'b1 || bus0.addr !== 32'h0) begin n_err++; $display("FAIL rm_first_req: got %b@%h want 1@00000000", bus0.req, bus0.addr); end
      @(negedge clock);
      e = sb.pop_front();
      n_vec++; if ({ii0, ip0, iv0} !== {e.instr, e.pc4, 1'b1}) begin n_err++; $display("FAIL rm_first_ifid: got %h/%h/%b want %h/%h/1", ii0, ip0, iv0, e.instr, e.pc4); end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_skid();
      test_discard();
      test_redirect_priority();
      test_reset_midwait();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
